// File: rtl/max11643_emulator.sv
// max11643_emulator
// Behavioural SPI-slave model of a MAX11643-style 8-bit ADC, running entirely
// in the ref_clk domain. It oversamples the SPI pins, decodes command bytes
// (setup, averaging, reset and conversion) and shifts the conversion result
// out on adc_dout.
//
// Ports:
//   ref_clk, reset_n        system clock, async active-low reset
//   adc_sclk/adc_cs/adc_din SPI inputs from the master (asynchronous)
//   adc_dout                registered SPI data to the master, MSB first
//   CH_DATA                 nine 8-bit samples, channel n at [8n+7:8n]
//   CMD, cmd_valid          last complete byte and its one-cycle strobe
//   SETUP_REG, AVG_REG      last setup / averaging register writes
//   CONV_CH, conv_strobe    channel of the last conversion and its strobe
//   cmd_err                 strobe for a conversion on a nonexistent channel
//
// Receive FSM:
//   state     | meaning
//   ST_IDLE   | cs high, waiting for a frame
//   ST_SHIFT  | cs low, collecting bits on SCLK rising edges
//   ST_DECODE | one cycle: CMD holds the new byte, decode happens here

module max11643_emulator #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        ref_clk,
    input  logic        reset_n,
    input  logic        adc_sclk,
    input  logic        adc_cs,
    input  logic        adc_din,
    output logic        adc_dout,
    input  logic [71:0] CH_DATA,
    output logic [7:0]  CMD,
    output logic        cmd_valid,
    output logic [7:0]  SETUP_REG,
    output logic [7:0]  AVG_REG,
    output logic [3:0]  CONV_CH,
    output logic        conv_strobe,
    output logic        cmd_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DECODE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;

    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  rx_q, rx_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  setup_q, setup_d;
    logic [7:0]  avg_q, avg_d;
    logic [3:0]  conv_ch_q, conv_ch_d;
    logic        conv_strobe_q, conv_strobe_d;
    logic        cmd_err_q, cmd_err_d;
    logic [15:0] res_q, res_d;
    logic [4:0]  res_cnt_q, res_cnt_d;
    logic        dout_q, dout_d;

    logic       sclk_s, cs_s, din_s;
    logic       sclk_rise, sclk_fall;
    logic       decode_en;
    logic [3:0] ch_sel;
    logic [7:0] ch_sample;

    // Synchronizer chains: stage 0 samples the pin, last stage is the clean copy.
    always_comb begin
        sclk_sync_d    = sclk_sync_q;
        cs_sync_d      = cs_sync_q;
        din_sync_d     = din_sync_q;
        sclk_sync_d[0] = adc_sclk;
        cs_sync_d[0]   = adc_cs;
        din_sync_d[0]  = adc_din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sclk_sync_d[i] = sclk_sync_q[i-1];
            cs_sync_d[i]   = cs_sync_q[i-1];
            din_sync_d[i]  = din_sync_q[i-1];
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign din_s       = din_sync_q[SYNC_STAGES-1];
    assign sclk_prev_d = sclk_s;
    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;

    // FSM: state register
    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!cs_s) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (cs_s)                                  state_d = ST_IDLE;
                else if (sclk_rise && bit_cnt_q == 3'd7)   state_d = ST_DECODE;
            end
            ST_DECODE: state_d = cs_s ? ST_IDLE : ST_SHIFT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        decode_en = (state_q == ST_DECODE);
        cmd_valid = decode_en;
    end

    // Conversion channel mux; channels above 8 read as zero.
    assign ch_sel = cmd_q[6:3];
    always_comb begin
        ch_sample = 8'h00;
        for (int i = 0; i < 9; i++) begin
            if (ch_sel == 4'(i)) ch_sample = CH_DATA[8*i +: 8];
        end
    end

    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        rx_d          = rx_q;
        cmd_d         = cmd_q;
        setup_d       = setup_q;
        avg_d         = avg_q;
        conv_ch_d     = conv_ch_q;
        conv_strobe_d = 1'b0;
        cmd_err_d     = 1'b0;
        res_d         = res_q;
        res_cnt_d     = res_cnt_q;

        // Receive path; a partial byte is dropped when cs rises mid-frame.
        if (state_q == ST_SHIFT) begin
            if (cs_s) begin
                bit_cnt_d = 3'd0;
                rx_d      = 7'd0;
            end else if (sclk_rise) begin
                rx_d      = {rx_q[5:0], din_s};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) cmd_d = {rx_q, din_s};
            end
        end

        // Readout shift; any decode that touches the result below overrides it.
        if (sclk_fall && !cs_s && res_cnt_q != 5'd0) begin
            res_d     = {res_q[14:0], 1'b0};
            res_cnt_d = res_cnt_q - 5'd1;
        end

        if (decode_en) begin
            casez (cmd_q)
                8'b1???????: begin
                    conv_ch_d = ch_sel;
                    res_cnt_d = 5'd16;
                    if (ch_sel <= 4'd8) begin
                        res_d         = {4'b0000, ch_sample, 4'b0000};
                        conv_strobe_d = 1'b1;
                    end else begin
                        res_d     = 16'h0000;
                        cmd_err_d = 1'b1;
                    end
                end
                8'b01??????: setup_d = cmd_q;
                8'b001?????: avg_d   = cmd_q;
                8'b0001????: begin
                    setup_d   = 8'h00;
                    avg_d     = 8'h00;
                    res_d     = 16'h0000;
                    res_cnt_d = 5'd0;
                end
                default: ;
            endcase
        end

        dout_d = (!cs_s && res_cnt_q != 5'd0) ? res_q[15] : 1'b0;
    end

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q   <= '0;
            cs_sync_q     <= '1;
            din_sync_q    <= '0;
            sclk_prev_q   <= 1'b0;
            bit_cnt_q     <= 3'd0;
            rx_q          <= 7'd0;
            cmd_q         <= 8'h00;
            setup_q       <= 8'h00;
            avg_q         <= 8'h00;
            conv_ch_q     <= 4'h0;
            conv_strobe_q <= 1'b0;
            cmd_err_q     <= 1'b0;
            res_q         <= 16'h0000;
            res_cnt_q     <= 5'd0;
            dout_q        <= 1'b0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            cs_sync_q     <= cs_sync_d;
            din_sync_q    <= din_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_q          <= rx_d;
            cmd_q         <= cmd_d;
            setup_q       <= setup_d;
            avg_q         <= avg_d;
            conv_ch_q     <= conv_ch_d;
            conv_strobe_q <= conv_strobe_d;
            cmd_err_q     <= cmd_err_d;
            res_q         <= res_d;
            res_cnt_q     <= res_cnt_d;
            dout_q        <= dout_d;
        end
    end

    assign adc_dout    = dout_q;
    assign CMD         = cmd_q;
    assign SETUP_REG   = setup_q;
    assign AVG_REG     = avg_q;
    assign CONV_CH     = conv_ch_q;
    assign conv_strobe = conv_strobe_q;
    assign cmd_err     = cmd_err_q;

endmodule
